lpc_synth: RTL and testbench

LPC_SYNTH -- requirements
Module: lpc_synth

---
 rtl/lpc_pkg.sv | 37 +++
 rtl/lpc_excitation.sv | 41 ++++
 rtl/lpc_synth.sv | 226 ++++++++++++++++++++++
 tb/tb_lpc_synth.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared constants, register map and FSM encoding for the LPC synthesis filter.
package lpc_pkg;

  localparam int unsigned LpcOrder = 10;
  localparam int unsigned LpcFrac  = 12;
  localparam int unsigned NumCoef  = 10;
  localparam int unsigned AccW     = 40;

  localparam logic [15:0] LfsrSeed = 16'hACE1;

  localparam logic [15:0] AddrPitch  = 16'd0;
  localparam logic [15:0] AddrGain   = 16'd1;
  localparam logic [15:0] AddrCtrl   = 16'd2;
  localparam logic [15:0] AddrStatus = 16'd3;

  localparam logic [7:0]  PitchRst = 8'd80;
  localparam logic [7:0]  PitchMin = 8'd2;
  localparam logic [15:0] GainRst  = 16'h8000;

  localparam logic signed [15:0]     PulseAmp = 16'sd8192;
  localparam logic signed [AccW-1:0] SatMax   = AccW'(32767);
  localparam logic signed [AccW-1:0] SatMin   = -AccW'(32768);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StExc  = 3'd1,
    StMac  = 3'd2,
    StRnd  = 3'd3,
    StOut  = 3'd4
  } lpc_state_e;

  // Fibonacci LFSR, taps 16,14,13,11, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/lpc_excitation.sv
// Excitation source: pitch-period impulse train (voiced) or scaled LFSR noise (unvoiced).
module lpc_excitation
  import lpc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_advance,
  input  logic               i_voiced,
  input  logic [7:0]         i_pitch,
  output logic signed [15:0] o_exc
);

  logic [7:0]  r_cnt;
  logic [15:0] r_lfsr;
  logic [7:0]  w_pitch_eff;

  assign w_pitch_eff = (i_pitch < PitchMin) ? PitchMin : i_pitch;

  // Output reflects the pre-advance state; the caller samples it in the advance cycle.
  always_comb begin
    o_exc = '0;
    if (i_voiced) begin
      if (r_cnt == '0) begin
        o_exc = PulseAmp;
      end
    end else begin
      o_exc = $signed(r_lfsr) >>> 2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_lfsr <= LfsrSeed;
    end else if (i_advance) begin
      r_cnt  <= (r_cnt == '0) ? (w_pitch_eff - 8'd1) : (r_cnt - 8'd1);
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

endmodule

// File: rtl/lpc_synth.sv
// All-pole LPC synthesis filter: one excitation sample per accepted d_clk tick, serial MAC
// over ORDER history taps, rounding/saturation, Avalon-MM control/status registers.
module lpc_synth
  import lpc_pkg::*;
#(
  parameter int unsigned ORDER = LpcOrder,  // at most NumCoef
  parameter int unsigned FRAC  = LpcFrac
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_clk,
  input  logic               v,
  input  logic               voiced,
  input  logic signed [15:0] A1,
  input  logic signed [15:0] A2,
  input  logic signed [15:0] A3,
  input  logic signed [15:0] A4,
  input  logic signed [15:0] A5,
  input  logic signed [15:0] A6,
  input  logic signed [15:0] A7,
  input  logic signed [15:0] A8,
  input  logic signed [15:0] A9,
  input  logic signed [15:0] A10,
  input  logic               coef_load,
  input  logic [15:0]        address,
  input  logic               read,
  input  logic               write,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic signed [15:0] y,
  output logic               y_valid
);

  localparam int unsigned KW = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam logic [KW-1:0] KMax = KW'(ORDER - 1);
  localparam logic signed [AccW-1:0] RndHalf = AccW'(1) <<< (FRAC - 1);

  lpc_state_e r_state, w_state_d;

  logic [1:0] r_sync;
  logic       r_dprev;
  logic       w_tick, w_accept, w_drop, w_busy, w_clr_ack;

  logic signed [15:0] w_a_in [NumCoef];
  logic signed [15:0] r_pend [ORDER];
  logic signed [15:0] r_shad [ORDER];
  logic signed [15:0] r_hist [ORDER];

  logic [KW-1:0]         r_k;
  logic signed [AccW-1:0] r_acc;
  logic signed [15:0]    r_y;
  logic                  r_y_valid;

  logic [7:0]  r_pitch;
  logic [15:0] r_gain;
  logic        r_clr;
  logic        r_ovr;
  logic [15:0] r_rdata, w_rdata;

  logic signed [15:0]     w_exc;
  logic signed [32:0]     w_eprod;
  logic signed [16:0]     w_e;
  logic signed [AccW-1:0] w_acc_init;
  logic signed [31:0]     w_mac_prod;
  logic signed [AccW-1:0] w_rsum, w_rsh;
  logic signed [15:0]     w_y_rnd;

  assign w_a_in[0] = A1;
  assign w_a_in[1] = A2;
  assign w_a_in[2] = A3;
  assign w_a_in[3] = A4;
  assign w_a_in[4] = A5;
  assign w_a_in[5] = A6;
  assign w_a_in[6] = A7;
  assign w_a_in[7] = A8;
  assign w_a_in[8] = A9;
  assign w_a_in[9] = A10;

  // d_clk is asynchronous to clk: two-flop synchronizer then rising-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_dprev <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], d_clk};
      r_dprev <= r_sync[1];
    end
  end

  assign w_tick    = r_sync[1] & ~r_dprev;
  assign w_busy    = (r_state != StIdle);
  assign w_accept  = w_tick & v & ~w_busy;
  assign w_drop    = w_tick & v & w_busy;
  assign w_clr_ack = r_clr & ~w_busy;

  lpc_excitation u_exc (
    .clk       (clk),
    .rst       (rst),
    .i_advance (r_state == StExc),
    .i_voiced  (voiced),
    .i_pitch   (r_pitch),
    .o_exc     (w_exc)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_d = StExc;
      StExc:   w_state_d = StMac;
      StMac:   if (r_k == KMax) w_state_d = StRnd;
      StRnd:   w_state_d = StOut;
      StOut:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_eprod    = 33'(w_exc) * 33'($signed({1'b0, r_gain}));
    w_e        = 17'(w_eprod >>> 16);
    w_acc_init = AccW'(w_e) <<< FRAC;
    w_mac_prod = 32'(r_shad[r_k]) * 32'(r_hist[r_k]);
    w_rsum     = r_acc + RndHalf;
    w_rsh      = w_rsum >>> FRAC;
    if (w_rsh > SatMax) begin
      w_y_rnd = 16'sh7FFF;
    end else if (w_rsh < SatMin) begin
      w_y_rnd = 16'sh8000;
    end else begin
      w_y_rnd = 16'(w_rsh);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_k       <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      for (int i = 0; i < ORDER; i++) begin
        r_shad[i] <= '0;
        r_hist[i] <= '0;
      end
    end else begin
      r_state   <= w_state_d;
      r_y_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          // Shadow only updates at sample start so a sample never sees mixed coefficients.
          if (w_accept) begin
            for (int i = 0; i < ORDER; i++) r_shad[i] <= r_pend[i];
          end
          if (r_clr) begin
            for (int i = 0; i < ORDER; i++) r_hist[i] <= '0;
          end
        end
        StExc: begin
          r_acc <= w_acc_init;
          r_k   <= '0;
        end
        StMac: begin
          r_acc <= r_acc - AccW'(w_mac_prod);
          r_k   <= (r_k == KMax) ? '0 : (r_k + 1'b1);
        end
        StRnd: begin
          r_y       <= w_y_rnd;
          r_y_valid <= 1'b1;
        end
        StOut: begin
          r_hist[0] <= r_y;
          for (int i = 1; i < ORDER; i++) r_hist[i] <= r_hist[i-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ORDER; i++) r_pend[i] <= '0;
    end else if (coef_load) begin
      for (int i = 0; i < ORDER; i++) r_pend[i] <= w_a_in[i];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      AddrPitch:  w_rdata = {8'h00, r_pitch};
      AddrGain:   w_rdata = r_gain;
      AddrCtrl:   w_rdata = {15'h0000, r_clr};
      AddrStatus: w_rdata = {14'h0000, r_ovr, w_busy};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pitch <= PitchRst;
      r_gain  <= GainRst;
      r_clr   <= 1'b0;
      r_ovr   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (write && (address == AddrPitch)) r_pitch <= writedata[7:0];
      if (write && (address == AddrGain))  r_gain  <= writedata;
      if (write && (address == AddrCtrl) && writedata[0]) begin
        r_clr <= 1'b1;
      end else if (w_clr_ack) begin
        r_clr <= 1'b0;
      end
      // A fresh overrun outranks a simultaneous write-1-clear.
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (write && (address == AddrStatus) && writedata[1]) begin
        r_ovr <= 1'b0;
      end
      if (read) r_rdata <= w_rdata;
    end
  end

  assign readdata = r_rdata;
  assign y        = r_y;
  assign y_valid  = r_y_valid;

endmodule

// File: tb/tb_lpc_synth.sv
// Self-checking bench for lpc_synth against a plain-arithmetic model of the synthesis equations.
module tb_lpc_synth;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d_clk = 1'b0, v = 1'b0, voiced = 1'b0, coef_load = 1'b0;
  logic signed [15:0] a [10];
  logic signed [15:0] nxt_a [10];
  logic [15:0] address = '0, writedata = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [15:0] readdata;
  logic signed [15:0] y;
  logic        y_valid;

  int n_vec = 0;
  int n_err = 0;

  longint      m_hist [10];
  longint      m_shad [10];
  longint      m_pend [10];
  int          m_cnt;
  logic [15:0] m_lfsr;
  int          m_pitch;
  longint      m_gain;

  always #10 clk = ~clk;

  lpc_synth dut (
    .clk(clk), .rst(rst), .d_clk(d_clk), .v(v), .voiced(voiced),
    .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]), .A5(a[4]),
    .A6(a[5]), .A7(a[6]), .A8(a[7]), .A9(a[8]), .A10(a[9]),
    .coef_load(coef_load), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .y(y), .y_valid(y_valid)
  );

  task automatic model_reset();
    for (int k = 0; k < 10; k++) begin
      m_hist[k] = 0; m_shad[k] = 0; m_pend[k] = 0;
    end
    m_cnt = 0; m_lfsr = 16'hACE1; m_pitch = 80; m_gain = 32768;
  endtask

  // y[n] = round((e << 12 - sum Ak*y[n-k]) / 4096), saturated to 16 bits.
  task automatic model_step(input bit vo, output logic signed [15:0] ym);
    longint exc, e, acc, r;
    int pe;
    logic signed [15:0] ls;
    for (int k = 0; k < 10; k++) m_shad[k] = m_pend[k];
    if (vo) begin
      exc = (m_cnt == 0) ? 64'sd8192 : 64'sd0;
    end else begin
      ls = m_lfsr;
      exc = longint'(ls) >>> 2;
    end
    e = (exc * m_gain) >>> 16;
    acc = e * 4096;
    for (int k = 0; k < 10; k++) acc = acc - m_shad[k] * m_hist[k];
    r = (acc + 2048) >>> 12;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    for (int k = 9; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = r;
    pe = (m_pitch < 2) ? 2 : m_pitch;
    m_cnt = (m_cnt == 0) ? pe - 1 : m_cnt - 1;
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    ym = 16'(r);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; d_clk = 1'b0; read = 1'b0; write = 1'b0; coef_load = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic avl_write(input logic [15:0] ad, input logic [15:0] d);
    @(posedge clk); #1;
    address = ad; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic avl_read(input logic [15:0] ad, output logic [15:0] d);
    @(posedge clk); #1;
    address = ad; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic load_coefs();
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      a[i] = nxt_a[i];
      m_pend[i] = nxt_a[i];
    end
    coef_load = 1'b1;
    @(posedge clk); #1;
    coef_load = 1'b0;
  endtask

  // One d_clk pulse, 40-cycle bounded window; optional coef_load of nxt_a at cycle load_at.
  task automatic run_sample(input int load_at, output logic signed [15:0] yo,
                            output int lat, output int npulse);
    lat = -1; npulse = 0; yo = y;
    @(posedge clk); #1;
    d_clk = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      coef_load = 1'b0;
      if (c == 4) d_clk = 1'b0;
      if (c == load_at) begin
        for (int i = 0; i < 10; i++) a[i] = nxt_a[i];
        coef_load = 1'b1;
      end
      if (y_valid) begin
        npulse++;
        if (lat < 0) begin
          lat = c;
          yo = y;
        end
      end
    end
    coef_load = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    do_reset();
    n_vec++;
    if (y !== 16'sd0 || y_valid !== 1'b0 || readdata !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_outputs: y=%0d y_valid=%b readdata=%h, want 0/0/0000", y, y_valid, readdata);
    end
    avl_read(16'd0, rd);
    n_vec++;
    if (rd !== 16'd80) begin n_err++; $display("FAIL reset_pitch: got %h want 0050", rd); end
    avl_read(16'd1, rd);
    n_vec++;
    if (rd !== 16'h8000) begin n_err++; $display("FAIL reset_gain: got %h want 8000", rd); end
    avl_read(16'd9, rd);
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL unmapped_read: got %h want 0000", rd); end
    avl_read(16'd3, rd);
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_status: got %h want 0000", rd); end
    avl_write(16'd0, 16'h0001);
    avl_read(16'd0, rd);
    n_vec++;
    if (rd !== 16'h0001) begin n_err++; $display("FAIL pitch_write: got %h want 0001", rd); end
  endtask

  task automatic test_impulse();
    logic signed [15:0] ym, yo;
    int lat, np;
    do_reset();
    for (int i = 0; i < 10; i++) nxt_a[i] = '0;
    load_coefs();
    v = 1'b1; voiced = 1'b1;
    for (int t = 0; t < 200; t++) begin
      model_step(1'b1, ym);
      run_sample(0, yo, lat, np);
      n_vec++;
      if (yo !== ym || lat != 15 || np != 1) begin
        n_err++;
        $display("FAIL impulse t=%0d: y=%0d lat=%0d pulses=%0d, want y=%0d lat=15 pulses=1",
                 t, yo, lat, np, ym);
      end
    end
  endtask

  task automatic test_one_pole();
    logic signed [15:0] ym, yo;
    int lat, np;
    do_reset();
    for (int i = 0; i < 10; i++) nxt_a[i] = '0;
    nxt_a[0] = -16'sd2048;
    load_coefs();
    v = 1'b1; voiced = 1'b1;
    for (int t = 0; t < 16; t++) begin
      model_step(1'b1, ym);
      run_sample(0, yo, lat, np);
      n_vec++;
      if (yo !== ym || np != 1) begin
        n_err++;
        $display("FAIL one_pole t=%0d: y=%0d pulses=%0d, want y=%0d pulses=1", t, yo, np, ym);
      end
      // Exact halving up to the LSB; round-half-up then holds the tail at 1.
      if (t <= 12) begin
        n_vec++;
        if (yo !== 16'(4096 >> t)) begin
          n_err++;
          $display("FAIL one_pole_halving t=%0d: y=%0d want %0d", t, yo, 4096 >> t);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] ym, yo;
    int lat, np;
    do_reset();
    for (int i = 0; i < 10; i++) nxt_a[i] = '0;
    nxt_a[0] = -16'sd8192;
    load_coefs();
    avl_write(16'd1, 16'hFFFF);
    m_gain = 65535;
    v = 1'b1; voiced = 1'b1;
    for (int t = 0; t < 20; t++) begin
      model_step(1'b1, ym);
      run_sample(0, yo, lat, np);
      n_vec++;
      if (yo !== ym || yo < 0) begin
        n_err++;
        $display("FAIL saturation t=%0d: y=%0d want %0d", t, yo, ym);
      end
    end
    n_vec++;
    if (y !== 16'sd32767) begin n_err++; $display("FAIL sat_hold: y=%0d want 32767", y); end
  endtask

  task automatic test_disable();
    logic signed [15:0] ym, yo, yhold;
    int lat, np;
    yhold = y;
    v = 1'b0;
    run_sample(0, yo, lat, np);
    n_vec++;
    if (np != 0 || y !== yhold) begin
      n_err++;
      $display("FAIL disabled_tick: pulses=%0d y=%0d, want pulses=0 y=%0d", np, y, yhold);
    end
    v = 1'b1;
    model_step(voiced, ym);
    run_sample(0, yo, lat, np);
    n_vec++;
    if (yo !== ym || np != 1) begin
      n_err++;
      $display("FAIL after_enable: y=%0d pulses=%0d, want y=%0d pulses=1", yo, np, ym);
    end
  endtask

  task automatic test_overrun();
    logic signed [15:0] ym, yo;
    logic [15:0] rd;
    int np;
    do_reset();
    v = 1'b1; voiced = 1'b1;
    model_step(1'b1, ym);
    np = 0; yo = '0;
    @(posedge clk); #1;
    d_clk = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 2) d_clk = 1'b0;
      if (c == 5) d_clk = 1'b1;
      if (c == 12) d_clk = 1'b0;
      if (y_valid) begin np++; yo = y; end
    end
    n_vec++;
    if (np != 1 || yo !== ym) begin
      n_err++;
      $display("FAIL overrun_single: pulses=%0d y=%0d, want pulses=1 y=%0d", np, yo, ym);
    end
    avl_read(16'd3, rd);
    n_vec++;
    if (rd !== 16'h0002) begin n_err++; $display("FAIL overrun_status: got %h want 0002", rd); end
    avl_write(16'd3, 16'h0002);
    avl_read(16'd3, rd);
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL overrun_clear: got %h want 0000", rd); end
  endtask

  task automatic test_coef_timing();
    logic signed [15:0] ym, yo;
    logic [15:0] w;
    int lat, np, la, tmp;
    do_reset();
    v = 1'b1;
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < 10; i++) begin
        tmp = int'($urandom_range(0, 8191)) - 4096;
        nxt_a[i] = 16'(tmp);
      end
      if ($urandom_range(0, 3) == 0) begin
        w = 16'($urandom_range(0, 12));
        avl_write(16'd0, w);
        m_pitch = int'(w);
      end
      if ($urandom_range(0, 3) == 0) begin
        w = 16'($urandom);
        avl_write(16'd1, w);
        m_gain = longint'(w);
      end
      if ($urandom_range(0, 7) == 0) begin
        avl_write(16'd2, 16'h0001);
        for (int k = 0; k < 10; k++) m_hist[k] = 0;
      end
      voiced = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        load_coefs();
        la = 0;
      end else begin
        la = int'($urandom_range(3, 30));
      end
      model_step(voiced, ym);
      run_sample(la, yo, lat, np);
      if (la != 0) begin
        for (int i = 0; i < 10; i++) m_pend[i] = nxt_a[i];
      end
      n_vec++;
      if (yo !== ym || lat != 15 || np != 1) begin
        n_err++;
        $display("FAIL coef_timing s=%0d load_at=%0d: y=%0d lat=%0d pulses=%0d, want y=%0d lat=15 pulses=1",
                 s, la, yo, lat, np, ym);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    logic signed [15:0] ym, yo;
    logic [15:0] rd;
    int lat, np, seen;
    v = 1'b1; voiced = 1'b1;
    seen = 0;
    @(posedge clk); #1;
    d_clk = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 4) d_clk = 1'b0;
      if (y_valid) seen++;
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (y !== 16'sd0 || y_valid !== 1'b0 || readdata !== 16'h0000) begin
      n_err++;
      $display("FAIL midmac_reset_outputs: y=%0d y_valid=%b readdata=%h, want 0/0/0000",
               y, y_valid, readdata);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (y_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL midmac_no_valid: pulses=%0d want 0", seen); end
    avl_read(16'd0, rd);
    n_vec++;
    if (rd !== 16'd80) begin n_err++; $display("FAIL midmac_pitch: got %h want 0050", rd); end
    avl_read(16'd1, rd);
    n_vec++;
    if (rd !== 16'h8000) begin n_err++; $display("FAIL midmac_gain: got %h want 8000", rd); end
    avl_read(16'd3, rd);
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL midmac_status: got %h want 0000", rd); end
    voiced = 1'b0;
    for (int t = 0; t < 3; t++) begin
      model_step(1'b0, ym);
      run_sample(0, yo, lat, np);
      n_vec++;
      if (yo !== ym || lat != 15 || np != 1) begin
        n_err++;
        $display("FAIL unvoiced_after_reset t=%0d: y=%0d lat=%0d pulses=%0d, want y=%0d lat=15 pulses=1",
                 t, yo, lat, np, ym);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      a[i] = '0;
      nxt_a[i] = '0;
    end
    model_reset();
    test_reset();
    test_impulse();
    test_one_pole();
    test_saturation();
    test_disable();
    test_overrun();
    test_coef_timing();
    test_reset_mid_mac();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
